// File: rtl/alu_seq.sv
// Sequential WIDTH-generic ALU with a start/done handshake, a shift-add multiplier
// and a registered C/L/F/Z/N flag set.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flagEn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             Lout,
  output logic             Fout,
  output logic             Zout,
  output logic             Nout
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_LUI = 4'b0110;
  localparam logic [3:0] OP_LSH = 4'b0111;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e               state_r, state_nxt_s;
  logic [WIDTH-1:0]     result_r, result_nxt_s;
  logic                 c_r, l_r, f_r, z_r, n_r;
  logic                 c_nxt_s, l_nxt_s, f_nxt_s, z_nxt_s, n_nxt_s;
  logic                 done_r, done_nxt_s;
  logic [2*WIDTH-1:0]   mcand_r, mcand_nxt_s;
  logic [2*WIDTH-1:0]   acc_r, acc_nxt_s, acc_step_s;
  logic [WIDTH-1:0]     mplier_r, mplier_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic                 fen_r, fen_nxt_s;

  logic [WIDTH:0]       sum_s, diff_s;
  logic [WIDTH-1:0]     shamt_s, lsh_s, lui_s;
  logic [WIDTH-1:0]     op_res_s;
  logic                 op_wres_s, op_wflag_s;
  logic                 op_c_s, op_l_s, op_f_s, op_z_s, op_n_s;

  // Zero and sign flags derived from a written result.
  function automatic logic [1:0] zn_flags(input logic [WIDTH-1:0] v);
    return {(v == {WIDTH{1'b0}}), v[WIDTH-1]};
  endfunction

  assign busy   = (state_r == S_MUL);
  assign done   = done_r;
  assign result = result_r;
  assign Cout   = c_r;
  assign Lout   = l_r;
  assign Fout   = f_r;
  assign Zout   = z_r;
  assign Nout   = n_r;

  // Shared arithmetic and the signed-distance shifter.
  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    diff_s  = {1'b0, b} - {1'b0, a};
    lui_s   = {a[HALF-1:0], b[HALF-1:0]};
    shamt_s = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    if (shamt_s >= W_VAL) begin
      lsh_s = {WIDTH{1'b0}};
    end else if (b[WIDTH-1]) begin
      lsh_s = a >> shamt_s;
    end else begin
      lsh_s = a << shamt_s;
    end
  end

  // Single-cycle opcode decode: candidate result, flags and write enables.
  always_comb begin
    op_res_s   = result_r;
    op_wres_s  = 1'b1;
    op_wflag_s = 1'b1;
    op_c_s     = 1'b0;
    op_l_s     = 1'b0;
    op_f_s     = 1'b0;
    op_z_s     = 1'b0;
    op_n_s     = 1'b0;
    case (aluControl)
      OP_NOP: begin
        op_wres_s  = 1'b0;
        op_wflag_s = 1'b0;
      end
      OP_SUB: begin
        op_res_s = diff_s[WIDTH-1:0];
        op_c_s   = diff_s[WIDTH];
        op_f_s   = (b[WIDTH-1] ^ a[WIDTH-1]) & (diff_s[WIDTH-1] ^ b[WIDTH-1]);
        {op_z_s, op_n_s} = zn_flags(diff_s[WIDTH-1:0]);
      end
      OP_CMP: begin
        op_wres_s = 1'b0;
        op_l_s    = (b < a);
        op_n_s    = ($signed(b) < $signed(a));
        op_z_s    = (a == b);
      end
      OP_AND: begin
        op_res_s = a & b;
        {op_z_s, op_n_s} = zn_flags(a & b);
      end
      OP_OR: begin
        op_res_s = a | b;
        {op_z_s, op_n_s} = zn_flags(a | b);
      end
      OP_XOR: begin
        op_res_s = a ^ b;
        {op_z_s, op_n_s} = zn_flags(a ^ b);
      end
      OP_LUI: begin
        op_res_s   = lui_s;
        op_wflag_s = 1'b0;
      end
      OP_LSH: begin
        op_res_s = lsh_s;
        {op_z_s, op_n_s} = zn_flags(lsh_s);
      end
      OP_ADD: begin
        op_res_s = sum_s[WIDTH-1:0];
        op_c_s   = sum_s[WIDTH];
        op_f_s   = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum_s[WIDTH-1] ^ a[WIDTH-1]);
        {op_z_s, op_n_s} = zn_flags(sum_s[WIDTH-1:0]);
      end
      default: begin
        // Reserved opcodes clear everything, including Z despite the zero result.
        op_res_s = {WIDTH{1'b0}};
      end
    endcase
  end

  assign acc_step_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  // Next-state, handshake and multiplier sequencing.
  always_comb begin
    state_nxt_s  = state_r;
    result_nxt_s = result_r;
    c_nxt_s      = c_r;
    l_nxt_s      = l_r;
    f_nxt_s      = f_r;
    z_nxt_s      = z_r;
    n_nxt_s      = n_r;
    done_nxt_s   = 1'b0;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    acc_nxt_s    = acc_r;
    cnt_nxt_s    = cnt_r;
    fen_nxt_s    = fen_r;
    case (state_r)
      S_IDLE: begin
        if (start && (aluControl == OP_MUL)) begin
          state_nxt_s  = S_MUL;
          mcand_nxt_s  = {{WIDTH{1'b0}}, a};
          mplier_nxt_s = b;
          acc_nxt_s    = {(2*WIDTH){1'b0}};
          cnt_nxt_s    = {CW{1'b0}};
          fen_nxt_s    = flagEn;
        end else if (start) begin
          done_nxt_s = 1'b1;
          if (op_wres_s) begin
            result_nxt_s = op_res_s;
          end else begin
            result_nxt_s = result_r;
          end
          if (flagEn && op_wflag_s) begin
            c_nxt_s = op_c_s;
            l_nxt_s = op_l_s;
            f_nxt_s = op_f_s;
            z_nxt_s = op_z_s;
            n_nxt_s = op_n_s;
          end else begin
            c_nxt_s = c_r;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MUL: begin
        acc_nxt_s    = acc_step_s;
        mcand_nxt_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
        mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
        cnt_nxt_s    = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
          state_nxt_s  = S_IDLE;
          done_nxt_s   = 1'b1;
          result_nxt_s = acc_step_s[WIDTH-1:0];
          if (fen_r) begin
            c_nxt_s = |acc_step_s[2*WIDTH-1:WIDTH];
            f_nxt_s = |acc_step_s[2*WIDTH-1:WIDTH];
            l_nxt_s = 1'b0;
            {z_nxt_s, n_nxt_s} = zn_flags(acc_step_s[WIDTH-1:0]);
          end else begin
            c_nxt_s = c_r;
          end
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, result, flag and multiplier registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      result_r <= {WIDTH{1'b0}};
      c_r      <= 1'b0;
      l_r      <= 1'b0;
      f_r      <= 1'b0;
      z_r      <= 1'b0;
      n_r      <= 1'b0;
      done_r   <= 1'b0;
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      fen_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      result_r <= result_nxt_s;
      c_r      <= c_nxt_s;
      l_r      <= l_nxt_s;
      f_r      <= f_nxt_s;
      z_r      <= z_nxt_s;
      n_r      <= n_nxt_s;
      done_r   <= done_nxt_s;
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      fen_r    <= fen_nxt_s;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq (WIDTH=16) against an integer reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   aluControl;
  logic [W-1:0] a, b;
  logic         flagEn;
  logic         busy, done;
  logic [W-1:0] result;
  logic         Cout, Lout, Fout, Zout, Nout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  longint m_res;
  bit     m_c, m_l, m_f, m_z, m_n;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .aluControl(aluControl),
    .a(a), .b(b), .flagEn(flagEn), .busy(busy), .done(done), .result(result),
    .Cout(Cout), .Lout(Lout), .Fout(Fout), .Zout(Zout), .Nout(Nout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic longint sgn(input longint v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference behaviour written from the opcode rules using integer arithmetic.
  task automatic model(input int op, input longint x, input longint y, input bit fen);
    longint r, p, sd;
    bit c, l, f, z, n, wr, wf, zn;
    r = m_res; c = 0; l = 0; f = 0; z = 0; n = 0; wr = 1; wf = 1; zn = 1;
    case (op)
      0: begin wr = 0; wf = 0; end
      1: begin
        r = (y - x + 65536) % 65536; c = (x > y);
        sd = sgn(y) - sgn(x); f = (sd > 32767) || (sd < -32768);
      end
      2: begin wr = 0; zn = 0; l = (y < x); n = (sgn(y) < sgn(x)); z = (x == y); end
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: begin r = (x % 256) * 256 + (y % 256); wf = 0; end
      7: begin
        sd = sgn(y);
        if (sd >= 0) r = (sd >= 16) ? 0 : (x * (64'sd1 << sd)) % 65536;
        else         r = (-sd >= 16) ? 0 : x / (64'sd1 << (-sd));
      end
      8: begin
        r = (x + y) % 65536; c = (x + y > 65535);
        sd = sgn(x) + sgn(y); f = (sd > 32767) || (sd < -32768);
      end
      9: begin p = x * y; r = p % 65536; c = (p > 65535); f = c; end
      default: begin r = 0; zn = 0; end
    endcase
    if (zn) begin z = (r == 0); n = (r >= 32768); end
    if (wr) m_res = r;
    if (fen && wf) begin m_c = c; m_l = l; m_f = f; m_z = z; m_n = n; end
  endtask

  task automatic model_reset();
    m_res = 0; m_c = 0; m_l = 0; m_f = 0; m_z = 0; m_n = 0;
  endtask

  // Issue one op, optionally poke start mid-multiply, then check the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit fen, input bit inject, output int bcyc);
    @(negedge clk);
    start = 1'b1; aluControl = op; a = x; b = y; flagEn = fen;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); aluControl = 4'($urandom);
    model(int'(op), longint'(x), longint'(y), fen);
    bcyc = 0;
    while (busy && bcyc < 100) begin
      if (inject && bcyc == 3) begin
        start = 1'b1; aluControl = 4'b1000; a = 16'h0001; b = 16'h0001; flagEn = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      bcyc++;
    end
    start = 1'b0;
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(m_res));
    chk({tag, " flags CLFZN"}, 64'({Cout, Lout, Fout, Zout, Nout}),
        64'({m_c, m_l, m_f, m_z, m_n}));
  endtask

  initial begin
    int bc, dcnt;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals [5];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000; edge_vals[4] = 16'hFFFF;

    reset = 1'b1; start = 1'b0; aluControl = 4'b0000; a = '0; b = '0; flagEn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset result", 64'(result), 64'd0);
    chk("reset flags", 64'({Cout, Lout, Fout, Zout, Nout}), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);

    run_op("add wrap", 4'b1000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, bc);
    chk("add wrap exact flags", 64'({Cout, Zout, Nout, Fout}), 64'(4'b1100));
    run_op("cmp", 4'b0010, 16'h0001, 16'hFFFF, 1'b1, 1'b0, bc);
    chk("cmp exact", 64'({Lout, Nout, Zout, result}), 64'({3'b010, 16'h0000}));
    run_op("sub noflag", 4'b0001, 16'h0003, 16'h0009, 1'b0, 1'b0, bc);
    chk("sub hold N", 64'(Nout), 64'd1);

    run_op("mul", 4'b1001, 16'h0123, 16'h0100, 1'b1, 1'b1, bc);
    chk("mul busy cycles", 64'(bc), 64'd16);
    chk("mul busy low at done", 64'(busy), 64'd0);
    chk("mul exact", 64'({Cout, Fout, result}), 64'({2'b11, 16'h2300}));
    @(posedge clk); #1;
    chk("no done after mul", 64'(done), 64'd0);
    chk("ignored start left result", 64'(result), 64'(16'h2300));

    run_op("lsh right", 4'b0111, 16'h8001, 16'hFFFF, 1'b1, 1'b0, bc);
    chk("lsh right exact", 64'(result), 64'(16'h4000));
    run_op("lsh left", 4'b0111, 16'h8001, 16'h0004, 1'b1, 1'b0, bc);
    chk("lsh left exact", 64'(result), 64'(16'h0010));
    run_op("lsh over", 4'b0111, 16'h8001, 16'h0010, 1'b1, 1'b0, bc);
    chk("lsh over exact", 64'({Zout, result}), 64'({1'b1, 16'h0000}));

    // Abort a multiply with reset during its fifth busy cycle.
    @(negedge clk);
    start = 1'b1; aluControl = 4'b1001; a = 16'h00FF; b = 16'h00FF; flagEn = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort flags", 64'({Cout, Lout, Fout, Zout, Nout}), 64'd0);
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no done after abort", 64'(dcnt), 64'd0);
    run_op("lui", 4'b0110, 16'h0012, 16'h0034, 1'b1, 1'b0, bc);
    chk("lui exact", 64'({Cout, Lout, Fout, Zout, Nout, result}), 64'({5'b00000, 16'h1234}));

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      if (rop == 4'b0111 && $urandom_range(0, 1) == 1) rb = W'($urandom_range(0, 40) - 20);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'($urandom), 1'b0, bc);
      if (rop == 4'b1001) chk($sformatf("rand%0d busy cycles", i), 64'(bc), 64'd16);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
